// File: rtl/register_file.sv
// MIPS general-purpose register file: 32 x 32-bit GPRs with two combinational
// read ports and one synchronous write port, plus the HI/LO pair written by
// the multiply/divide unit. Register 0 is hard-wired to zero. An optional
// write-to-read bypass forwards write-back data to decode in the same cycle.
module register_file #(
    parameter int                 WIDTH     = 32,
    parameter int                 ADDR_BITS = 5,
    parameter int                 BYPASS    = 1,
    parameter logic [WIDTH-1:0]   SP_RESET  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_BITS-1:0]  read_reg1,
    input  logic [ADDR_BITS-1:0]  read_reg2,
    output logic [WIDTH-1:0]      read_data1,
    output logic [WIDTH-1:0]      read_data2,
    input  logic                  write_enable,
    input  logic [ADDR_BITS-1:0]  write_reg,
    input  logic [WIDTH-1:0]      write_data,
    input  logic                  hi_lo_write,
    input  logic [WIDTH-1:0]      hi_in,
    input  logic [WIDTH-1:0]      lo_in,
    output logic [WIDTH-1:0]      hi_out,
    output logic [WIDTH-1:0]      lo_out
);

    localparam int DEPTH  = 2 ** ADDR_BITS;
    localparam int SP_IDX = 29;

    logic [WIDTH-1:0] gpr_q [DEPTH];
    logic [WIDTH-1:0] gpr_d [DEPTH];
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             wr_valid;
    logic             byp_hit1;
    logic             byp_hit2;
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    // A write to index 0 is dropped so the zero register never changes.
    assign wr_valid = write_enable && (write_reg != '0);

    // Per-register write-enable feedback mux: hold unless this index is written.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            gpr_d[i] = gpr_q[i];
            if (wr_valid && (write_reg == ADDR_BITS'(i))) begin
                gpr_d[i] = write_data;
            end
        end
        gpr_d[0] = '0;
    end

    // HI/LO are committed together, independently of the GPR port.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_lo_write) begin
            hi_d = hi_in;
            lo_d = lo_in;
        end
    end

    // GPR storage; synchronous reset wins over any write presented that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
        end
    end

    // HI/LO storage with the same reset priority as the GPRs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Stored-value read path; index 0 always reads as zero.
    always_comb begin
        stored1 = (read_reg1 == '0) ? '0 : gpr_q[read_reg1];
        stored2 = (read_reg2 == '0) ? '0 : gpr_q[read_reg2];
    end

    // Forwarding is suppressed while reset is low so reads show stored state.
    always_comb begin
        byp_hit1 = (BYPASS != 0) && reset && wr_valid && (write_reg == read_reg1);
        byp_hit2 = (BYPASS != 0) && reset && wr_valid && (write_reg == read_reg2);
    end

    // Final read muxes: forwarded write data takes precedence over storage.
    always_comb begin
        read_data1 = byp_hit1 ? write_data : stored1;
        read_data2 = byp_hit2 ? write_data : stored2;
    end

    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one bypassing and one non-bypassing
// instance share the same stimulus; expected values are hand-computed.
module tb_register_file;

    localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;

    logic        clk;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic        write_enable, hi_lo_write;
    logic [31:0] write_data, hi_in, lo_in;
    logic [31:0] a_rd1, a_rd2, a_hi, a_lo;
    logic [31:0] b_rd1, b_rd2, b_hi, b_lo;

    int n_cmp = 0;
    int n_err = 0;

    register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(1), .SP_RESET(SP_VAL)) dut_a (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(a_rd1), .read_data2(a_rd2),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .hi_lo_write(hi_lo_write), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(a_hi), .lo_out(a_lo)
    );

    register_file #(.WIDTH(32), .ADDR_BITS(5), .BYPASS(0), .SP_RESET(SP_VAL)) dut_b (
        .clk(clk), .reset(reset),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(b_rd1), .read_data2(b_rd2),
        .write_enable(write_enable), .write_reg(write_reg), .write_data(write_data),
        .hi_lo_write(hi_lo_write), .hi_in(hi_in), .lo_in(lo_in),
        .hi_out(b_hi), .lo_out(b_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change well clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp;

        reset = 1'b0; write_enable = 1'b0; hi_lo_write = 1'b0;
        read_reg1 = '0; read_reg2 = '0; write_reg = '0;
        write_data = '0; hi_in = '0; lo_in = '0;

        // Reset edge with a write pending that must be dropped.
        write_enable = 1'b1; write_reg = 5'd3; write_data = 32'h0BAD_0BAD;
        hi_lo_write = 1'b1; hi_in = 32'h1111_1111; lo_in = 32'h2222_2222;
        tick();
        reset = 1'b1; write_enable = 1'b0; hi_lo_write = 1'b0;

        // Reset values on every index, both ports, both variants.
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            #1;
            exp = (i == 29) ? SP_VAL : 32'h0;
            check("rst_a_p1", a_rd1, exp);
            check("rst_b_p1", b_rd1, exp);
            exp = ((31 - i) == 29) ? SP_VAL : 32'h0;
            check("rst_a_p2", a_rd2, exp);
            check("rst_b_p2", b_rd2, exp);
        end
        check("rst_hi_a", a_hi, 32'h0);
        check("rst_lo_a", a_lo, 32'h0);
        check("rst_hi_b", b_hi, 32'h0);
        check("rst_lo_b", b_lo, 32'h0);

        // Plain write to reg 8, read back next cycle on both ports.
        write_enable = 1'b1; write_reg = 5'd8; write_data = 32'hDEAD_BEEF;
        tick();
        write_enable = 1'b0; read_reg1 = 5'd8; read_reg2 = 5'd8;
        #1;
        check("w8_a_p1", a_rd1, 32'hDEAD_BEEF);
        check("w8_a_p2", a_rd2, 32'hDEAD_BEEF);
        check("w8_b_p1", b_rd1, 32'hDEAD_BEEF);
        check("w8_b_p2", b_rd2, 32'hDEAD_BEEF);

        // Writes to reg 0 are ignored and never forwarded.
        write_enable = 1'b1; write_reg = 5'd0; write_data = 32'h1234_5678;
        read_reg1 = 5'd0; read_reg2 = 5'd8;
        #1;
        check("w0_byp_a", a_rd1, 32'h0);
        check("w0_other_a", a_rd2, 32'hDEAD_BEEF);
        tick();
        write_enable = 1'b0;
        #1;
        check("w0_a", a_rd1, 32'h0);
        check("w0_b", b_rd1, 32'h0);

        // Same-cycle bypass to both ports; non-bypass instance shows old value.
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hCAFE_0001;
        read_reg1 = 5'd5; read_reg2 = 5'd5;
        #1;
        check("byp_a_p1", a_rd1, 32'hCAFE_0001);
        check("byp_a_p2", a_rd2, 32'hCAFE_0001);
        check("nobyp_b_p1", b_rd1, 32'h0);
        check("nobyp_b_p2", b_rd2, 32'h0);
        tick();
        write_enable = 1'b0;
        #1;
        check("post_b_p1", b_rd1, 32'hCAFE_0001);
        check("post_a_p2", a_rd2, 32'hCAFE_0001);

        // Seed reg 31, then reset together with a write to it.
        write_enable = 1'b1; write_reg = 5'd31; write_data = 32'h0000_0031;
        tick();
        reset = 1'b0; write_data = 32'hAAAA_AAAA;
        read_reg1 = 5'd31; read_reg2 = 5'd8;
        #1;
        check("rstw_nobyp_a", a_rd1, 32'h0000_0031);
        check("rstw_nobyp_b", b_rd1, 32'h0000_0031);
        tick();
        reset = 1'b1; write_enable = 1'b0;
        #1;
        check("rstw_r31_a", a_rd1, 32'h0);
        check("rstw_r31_b", b_rd1, 32'h0);
        check("rstw_r8_a", a_rd2, 32'h0);
        read_reg1 = 5'd29; read_reg2 = 5'd5;
        #1;
        check("rstw_sp_a", a_rd1, SP_VAL);
        check("rstw_r5_b", b_rd2, 32'h0);

        // HI/LO write concurrent with a GPR write; HI/LO never bypassed.
        hi_lo_write = 1'b1; hi_in = 32'h0000_0001; lo_in = 32'hFFFF_FFFE;
        write_enable = 1'b1; write_reg = 5'd2; write_data = 32'h0000_0055;
        read_reg1 = 5'd2; read_reg2 = 5'd29;
        #1;
        check("hilo_pre_hi", a_hi, 32'h0);
        check("hilo_pre_lo", a_lo, 32'h0);
        tick();
        hi_lo_write = 1'b0; write_enable = 1'b0;
        #1;
        check("hilo_hi_a", a_hi, 32'h0000_0001);
        check("hilo_lo_a", a_lo, 32'hFFFF_FFFE);
        check("hilo_hi_b", b_hi, 32'h0000_0001);
        check("hilo_lo_b", b_lo, 32'hFFFF_FFFE);
        check("hilo_r2_a", a_rd1, 32'h0000_0055);
        check("hilo_r2_b", b_rd1, 32'h0000_0055);
        check("hilo_sp_b", b_rd2, SP_VAL);

        // Back-to-back writes to reg 17 with reads every cycle.
        read_reg1 = 5'd17; read_reg2 = 5'd2;
        for (int k = 1; k <= 3; k++) begin
            write_enable = 1'b1; write_reg = 5'd17; write_data = 32'(k);
            #1;
            check("b2b_byp_a", a_rd1, 32'(k));
            check("b2b_old_b", b_rd1, 32'(k - 1));
            check("b2b_p2_a", a_rd2, 32'h0000_0055);
            tick();
        end
        write_enable = 1'b0;
        #1;
        check("b2b_final_a", a_rd1, 32'd3);
        check("b2b_final_b", b_rd1, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
